// File: rtl/stream_source_pkg.sv
// Shared stream definitions: word layout, widths and the phase-state encoding
// used by every stream stage.
package stream_source_pkg;

  localparam int unsigned StreamW     = 26;
  localparam int unsigned CoordW      = 10;
  localparam int unsigned RgbW        = 3;

  localparam int unsigned StActiveBit = 25;
  localparam int unsigned StHsyncBit  = 24;
  localparam int unsigned StVsyncBit  = 23;
  localparam int unsigned StXLsb      = 13;
  localparam int unsigned StYLsb      = 3;
  localparam int unsigned StRgbLsb    = 0;

  // PhActive must stay at zero so that reset leaves both phases ACTIVE.
  typedef enum logic [1:0] {
    PhActive = 2'd0,
    PhFront  = 2'd1,
    PhSync   = 2'd2,
    PhBack   = 2'd3
  } phase_e;

endpackage

// File: rtl/stream_source_if.sv
// Stream-side bundle of the video timing source: count enable in, stream word and
// line/frame ticks out.
interface stream_source_if;
  import stream_source_pkg::*;

  logic               en;
  logic [StreamW-1:0] strRGB_o;
  logic               line_tick;
  logic               frame_tick;

  modport master (
    input  en,
    output strRGB_o,
    output line_tick,
    output frame_tick
  );

  modport slave (
    output en,
    input  strRGB_o,
    input  line_tick,
    input  frame_tick
  );

endinterface

// File: rtl/stream_source_sync_counter.sv
// One timing axis: wrapping counter plus a four-phase FSM (active, front porch,
// sync, back porch) that steps at the phase-length boundaries.
module sync_counter
  import stream_source_pkg::*;
#(
  parameter int unsigned Active = 640,
  parameter int unsigned Front  = 16,
  parameter int unsigned Sync   = 96,
  parameter int unsigned Back   = 48
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              advance_i,
  output logic [CoordW-1:0] count_o,
  output phase_e            phase_o,
  output logic              wrap_o
);

  localparam int unsigned Total = Active + Front + Sync + Back;

  localparam logic [CoordW-1:0] LastActive = CoordW'(Active - 1);
  localparam logic [CoordW-1:0] LastFront  = CoordW'(Active + Front - 1);
  localparam logic [CoordW-1:0] LastSync   = CoordW'(Active + Front + Sync - 1);
  localparam logic [CoordW-1:0] LastCount  = CoordW'(Total - 1);

  logic [CoordW-1:0] count_q, count_d;
  phase_e            phase_q, phase_d;
  logic              at_last;

  assign at_last = (count_q == LastCount);
  assign wrap_o  = advance_i & at_last;

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (advance_i) begin
      count_d = at_last ? '0 : count_q + 1'b1;
      unique case (phase_q)
        PhActive: if (count_q == LastActive) phase_d = PhFront;
        PhFront:  if (count_q == LastFront)  phase_d = PhSync;
        PhSync:   if (count_q == LastSync)   phase_d = PhBack;
        PhBack:   if (at_last)               phase_d = PhActive;
        default:                             phase_d = PhActive;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      phase_q <= PhActive;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count_o = count_q;
  assign phase_o = phase_q;

endmodule

// File: rtl/stream_source.sv
// Video timing source: H/V counters with phase FSMs, producing a registered
// stream word (active, syncs, x, y, rgb) and line/frame ticks one clock later.
module stream_source
  import stream_source_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter logic [RgbW-1:0] bg_color = 3'b000
) (
  input  logic            px_clk,
  input  logic            reset_n,
  stream_source_if.master sif
);

  localparam logic [CoordW-1:0] FrameLine = CoordW'(V_ACTIVE);

  logic [CoordW-1:0] hc, vc;
  phase_e            h_phase, v_phase;
  logic              h_wrap;
  logic              unused_v_wrap;

  sync_counter #(
    .Active (H_ACTIVE),
    .Front  (H_FRONT),
    .Sync   (H_SYNC),
    .Back   (H_BACK)
  ) u_h_counter (
    .clk_i     (px_clk),
    .rst_ni    (reset_n),
    .advance_i (sif.en),
    .count_o   (hc),
    .phase_o   (h_phase),
    .wrap_o    (h_wrap)
  );

  sync_counter #(
    .Active (V_ACTIVE),
    .Front  (V_FRONT),
    .Sync   (V_SYNC),
    .Back   (V_BACK)
  ) u_v_counter (
    .clk_i     (px_clk),
    .rst_ni    (reset_n),
    .advance_i (sif.en & h_wrap),
    .count_o   (vc),
    .phase_o   (v_phase),
    .wrap_o    (unused_v_wrap)
  );

  logic [StreamW-1:0] word_q, word_d;
  logic               line_q, line_d;
  logic               frame_q, frame_d;
  logic               active;

  assign active = (h_phase == PhActive) && (v_phase == PhActive);

  // The word describes the counters as held before the edge; en low freezes it.
  always_comb begin
    word_d  = word_q;
    line_d  = line_q;
    frame_d = frame_q;
    if (sif.en) begin
      word_d                       = '0;
      word_d[StActiveBit]          = active;
      word_d[StHsyncBit]           = (h_phase == PhSync);
      word_d[StVsyncBit]           = (v_phase == PhSync);
      word_d[StXLsb +: CoordW]     = hc;
      word_d[StYLsb +: CoordW]     = vc;
      word_d[StRgbLsb +: RgbW]     = active ? bg_color : '0;
      line_d                       = (hc == '0);
      frame_d                      = (hc == '0) && (vc == FrameLine);
    end
  end

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q  <= '0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign sif.strRGB_o   = word_q;
  assign sif.line_tick  = line_q;
  assign sif.frame_tick = frame_q;

endmodule

// File: tb/tb_stream_source.sv
// Randomised-enable bench for stream_source: three parameterisations checked every
// cycle against a coordinate-based timing model, plus tick and sync tallies.
module tb_stream_source;

  localparam int HA [3] = '{640, 4, 40};
  localparam int HF [3] = '{16,  1, 4};
  localparam int HS [3] = '{96,  2, 8};
  localparam int HB [3] = '{48,  1, 4};
  localparam int VA [3] = '{480, 3, 30};
  localparam int VF [3] = '{10,  1, 3};
  localparam int VS [3] = '{2,   1, 2};
  localparam int VB [3] = '{33,  1, 4};
  localparam logic [2:0] BG [3] = '{3'b101, 3'b011, 3'b110};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_tb = 1'b0;

  always #5 clk = ~clk;

  stream_source_if if_a ();
  stream_source_if if_b ();
  stream_source_if if_c ();

  assign if_a.en = en_tb;
  assign if_b.en = en_tb;
  assign if_c.en = en_tb;

  stream_source #(.bg_color(3'b101)) u_dut_a (
    .px_clk  (clk),
    .reset_n (rst_n),
    .sif     (if_a)
  );

  stream_source #(
    .H_ACTIVE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
    .V_ACTIVE (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .bg_color (3'b011)
  ) u_dut_b (
    .px_clk  (clk),
    .reset_n (rst_n),
    .sif     (if_b)
  );

  stream_source #(
    .H_ACTIVE (40), .H_FRONT (4), .H_SYNC (8), .H_BACK (4),
    .V_ACTIVE (30), .V_FRONT (3), .V_SYNC (2), .V_BACK (4),
    .bg_color (3'b110)
  ) u_dut_c (
    .px_clk  (clk),
    .reset_n (rst_n),
    .sif     (if_c)
  );

  logic [27:0] obs [3];
  assign obs[0] = {if_a.frame_tick, if_a.line_tick, if_a.strRGB_o};
  assign obs[1] = {if_b.frame_tick, if_b.line_tick, if_b.strRGB_o};
  assign obs[2] = {if_c.frame_tick, if_c.line_tick, if_c.strRGB_o};

  int          n_checks = 0;
  int          n_fail   = 0;
  int          mx [3];
  int          my [3];
  logic [27:0] expw [3];

  task automatic check_eq(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {frame_tick, line_tick, word} for a pixel at (x, y) of instance i.
  function automatic logic [27:0] model_word(input int i, input int x, input int y);
    logic act, hsy, vsy;
    logic [2:0] rgb;
    act = (x < HA[i]) && (y < VA[i]);
    hsy = (x >= HA[i] + HF[i]) && (x < HA[i] + HF[i] + HS[i]);
    vsy = (y >= VA[i] + VF[i]) && (y < VA[i] + VF[i] + VS[i]);
    rgb = act ? BG[i] : 3'b000;
    return {(x == 0) && (y == VA[i]), x == 0, act, hsy, vsy, 10'(x), 10'(y), rgb};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mx[i]   = 0;
      my[i]   = 0;
      expw[i] = '0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) check_eq($sformatf("word_inst%0d", i), obs[i], expw[i]);
  endtask

  task automatic step(input logic en_v);
    en_tb = en_v;
    @(posedge clk);
    #1;
    if (rst_n && en_v) begin
      for (int i = 0; i < 3; i++) begin
        expw[i] = model_word(i, mx[i], my[i]);
        mx[i]++;
        if (mx[i] == HA[i] + HF[i] + HS[i] + HB[i]) begin
          mx[i] = 0;
          my[i]++;
          if (my[i] == VA[i] + VF[i] + VS[i] + VB[i]) my[i] = 0;
        end
      end
    end
    check_all();
  endtask

  int line_cnt;
  int frame_cnt;
  int vsync_cnt;
  int guard;

  initial begin
    model_reset();
    #1;
    check_all();
    for (int k = 0; k < 3; k++) step(1'b0);
    for (int k = 0; k < 3; k++) step(1'b1);
    rst_n = 1'b1;

    // First line of the default timing, continuous enable.
    line_cnt = 0;
    for (int k = 0; k < 800; k++) begin
      step(1'b1);
      if (if_a.line_tick) line_cnt++;
    end
    check_eq("a_line_ticks_one_line", 28'(line_cnt), 28'd1);

    // Stall with x=300 on the stream.
    guard = 0;
    while (mx[0] != 300 && guard < 1000) begin
      step(1'b1);
      guard++;
    end
    check_eq("a_reach_x300_bound", 28'(guard < 1000), 28'd1);
    step(1'b1);
    for (int k = 0; k < 5; k++) step(1'b0);
    check_eq("a_hold_x300", 28'(if_a.strRGB_o[22:13]), 28'd300);
    step(1'b1);
    check_eq("a_resume_x301", 28'(if_a.strRGB_o[22:13]), 28'd301);

    // Random enable.
    for (int k = 0; k < 3000; k++) step(1'(($urandom_range(0, 4) != 0)));

    // Asynchronous reset with x=123 on the stream.
    guard = 0;
    while (mx[0] != 123 && guard < 1000) begin
      step(1'b1);
      guard++;
    end
    step(1'b1);
    check_eq("a_pre_reset_x123", 28'(if_a.strRGB_o[22:13]), 28'd123);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    step(1'b1);
    step(1'b1);
    rst_n = 1'b1;

    // One full frame of instance C from reset release.
    frame_cnt = 0;
    vsync_cnt = 0;
    for (int k = 0; k < 56 * 39; k++) begin
      step(1'b1);
      if (k == 0) check_eq("c_first_word_xy", 28'(if_c.strRGB_o[22:3]), 28'd0);
      if (if_c.frame_tick) frame_cnt++;
      if (if_c.strRGB_o[23]) vsync_cnt++;
    end
    check_eq("c_frame_ticks", 28'(frame_cnt), 28'd1);
    check_eq("c_vsync_words", 28'(vsync_cnt), 28'd112);
    step(1'b1);
    check_eq("c_wrap_xy", 28'(if_c.strRGB_o[22:3]), 28'd0);

    for (int k = 0; k < 200; k++) step(1'(($urandom_range(0, 2) != 0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
